// File: rtl/axi_line_fill_if.sv
// Bundle of the cache refill port and the AXI4 read channels used by axi_line_fill.
// master = the line-fill block, slave = the cache/interconnect side.
interface axi_line_fill_if;
  logic        miss;
  logic [31:0] miss_addr;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_wstb;
  logic        mem_data_valid;
  logic        mem_last;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        busy;
  logic        fill_err;

  modport master (
    input  miss, miss_addr, arready, rdata, rresp, rlast, rvalid,
    output mem_addr, mem_data_in, mem_wstb, mem_data_valid, mem_last,
           arid, araddr, arlen, arsize, arburst, arvalid, rready, busy, fill_err
  );

  modport slave (
    output miss, miss_addr, arready, rdata, rresp, rlast, rvalid,
    input  mem_addr, mem_data_in, mem_wstb, mem_data_valid, mem_last,
           arid, araddr, arlen, arsize, arburst, arvalid, rready, busy, fill_err
  );
endinterface

// File: rtl/axi_line_fill.sv
// Refill responder: fetches a 128-byte line as one 32-beat AXI4 INCR burst and
// replays it to the cache as single-word beats with a trailing mem_last pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for miss; base/cnt/fill_err loaded on exit
// ADDR     | arvalid held with araddr = base until arready
// DATA     | accepting beats, at most one every other cycle
// LAST     | final beat is being presented; mem_last follows next cycle
// WAIT_CLR | fill done, waiting for the cache to drop miss
module axi_line_fill #(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         LINE_BYTES = 128
) (
  input logic            clk,
  input logic            reset,
  axi_line_fill_if.master bus
);

  localparam logic [5:0] LAST_CNT = 6'(LINE_BYTES / 4 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_LAST,
    S_WAIT_CLR
  } state_t;

  state_t      state_q, state_d;
  logic [24:0] base_q, base_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        mem_dv_q, mem_dv_d;
  logic        mem_last_q, mem_last_d;
  logic        fill_err_q, fill_err_d;
  logic        beat_acc;
  logic        beat_bad;
  logic        unused_bits;

  // The line offset of the miss is dropped: fills always start at word 0.
  assign unused_bits = ^bus.miss_addr[6:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_dv_q   <= 1'b0;
      mem_last_q <= 1'b0;
      fill_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_dv_q   <= mem_dv_d;
      mem_last_q <= mem_last_d;
      fill_err_q <= fill_err_d;
    end
  end

  // rready is withheld while a beat is on mem_*, which keeps mem_data_valid a single-cycle pulse.
  assign bus.rready = (state_q == S_DATA) && !mem_dv_q;
  assign beat_acc   = bus.rready && bus.rvalid;
  assign beat_bad   = (bus.rresp != 2'b00) || (bus.rlast != (cnt_q == LAST_CNT));

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_dv_d   = 1'b0;
    fill_err_d = fill_err_q;
    // LAST coincides with the final mem_data_valid, so the end marker trails it by one cycle.
    mem_last_d = (state_q == S_LAST);

    case (state_q)
      S_IDLE: begin
        if (bus.miss) begin
          base_d     = bus.miss_addr[31:7];
          cnt_d      = '0;
          fill_err_d = 1'b0;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.arready) state_d = S_DATA;
      end
      S_DATA: begin
        if (beat_acc) begin
          mem_data_d = bus.rdata;
          mem_addr_d = {base_q, cnt_q[4:0], 2'b00};
          mem_dv_d   = 1'b1;
          cnt_d      = cnt_q + 6'd1;
          if (beat_bad) fill_err_d = 1'b1;
          if (cnt_q == LAST_CNT) state_d = S_LAST;
        end
      end
      S_LAST: begin
        state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        if (!bus.miss) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.arvalid        = (state_q == S_ADDR);
  assign bus.araddr         = {base_q, 7'b0};
  assign bus.arid           = AXI_ID;
  assign bus.arlen          = 8'd31;
  assign bus.arsize         = 3'b010;
  assign bus.arburst        = 2'b01;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_data_in    = mem_data_q;
  assign bus.mem_wstb       = 4'b1111;
  assign bus.mem_data_valid = mem_dv_q;
  assign bus.mem_last       = mem_last_q;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.fill_err       = fill_err_q;

endmodule

// File: tb/tb_axi_line_fill.sv
// Directed bench for axi_line_fill: drives a miss and an AXI read slave,
// checks the refill beats, handshakes, error flag and async reset.
module tb_axi_line_fill;
  logic clk;
  logic reset;
  int   n_pass;
  int   n_fail;
  int   n_total;

  axi_line_fill_if bus ();

  axi_line_fill #(.AXI_ID(4'h3), .LINE_BYTES(128)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // One complete line fill. bad_beat / early_last are beat indices (-1 = none);
  // abort_at > 0 asserts reset right after that many mem_data_valid pulses.
  task automatic do_fill(input string tag, input logic [31:0] maddr, input int ar_delay,
                         input int rv_pct, input bit alt_data, input int bad_beat,
                         input int early_last, input int abort_at, input bit pre_err,
                         input bit exp_err);
    logic [31:0] base;
    logic [31:0] exp_d [32];
    int sent, got, cyc, hs_last, last_seen, last_cnt, bad_seq, bad_beat_cnt, consec, bad_hold;
    bit dv_due, prev_dv, done, pend;

    base = {maddr[31:7], 7'b0};
    chk({tag, ".err_before"}, 32'(bus.fill_err), 32'(pre_err));
    bus.miss      = 1'b1;
    bus.miss_addr = maddr;
    tick();
    chk({tag, ".arvalid"}, 32'(bus.arvalid), 32'd1);
    chk({tag, ".araddr"}, bus.araddr, base);
    chk({tag, ".arlen"}, 32'(bus.arlen), 32'd31);
    chk({tag, ".err_cleared"}, 32'(bus.fill_err), 32'd0);

    bad_seq = 0;
    for (int d = 0; d < ar_delay; d++) begin
      if (bus.arvalid !== 1'b1 || bus.araddr !== base || bus.rready !== 1'b0) bad_seq++;
      tick();
    end
    bus.arready = 1'b1;
    if (bus.arvalid !== 1'b1 || bus.araddr !== base || bus.rready !== 1'b0) bad_seq++;
    tick();
    bus.arready = 1'b0;
    chk({tag, ".ar_hold"}, 32'(bad_seq), 32'd0);
    chk({tag, ".rready_after_ar"}, 32'(bus.rready), 32'd1);

    sent = 0; got = 0; cyc = 0; hs_last = -100; last_seen = -1; last_cnt = 0;
    bad_beat_cnt = 0; consec = 0; bad_hold = 0;
    dv_due = 0; prev_dv = 0; done = 0; pend = 0;
    while (!done && cyc < 800) begin
      if (bus.mem_data_valid !== dv_due) bad_beat_cnt++;
      if (bus.mem_data_valid === 1'b1) begin
        if (prev_dv) consec++;
        if (got < 32) begin
          if (bus.mem_addr !== base + 32'(got * 4) || bus.mem_data_in !== exp_d[got])
            bad_beat_cnt++;
        end
        got++;
      end else if (got > 0 && got <= 32) begin
        if (bus.mem_addr !== base + 32'((got - 1) * 4) || bus.mem_data_in !== exp_d[got - 1])
          bad_hold++;
      end
      prev_dv = (bus.mem_data_valid === 1'b1);
      if (bus.mem_last === 1'b1) begin
        last_cnt++;
        if (last_seen < 0) last_seen = cyc;
      end

      if (abort_at > 0 && got == abort_at) begin
        chk({tag, ".err_pre_reset"}, 32'(bus.fill_err), 32'(exp_err));
        bus.rvalid = 1'b0;
        bus.miss   = 1'b0;
        reset      = 1'b1;
        #1;
        chk({tag, ".rst_arvalid"}, 32'(bus.arvalid), 32'd0);
        chk({tag, ".rst_rready"}, 32'(bus.rready), 32'd0);
        chk({tag, ".rst_dv"}, 32'(bus.mem_data_valid), 32'd0);
        chk({tag, ".rst_last"}, 32'(bus.mem_last), 32'd0);
        chk({tag, ".rst_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, ".rst_err"}, 32'(bus.fill_err), 32'd0);
        return;
      end

      dv_due = 1'b0;
      if (sent < 32 && (pend || rv_pct >= 100 || $urandom_range(99) < rv_pct)) begin
        bus.rvalid = 1'b1;
        bus.rdata  = alt_data ? ((sent % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555) : 32'(sent);
        bus.rresp  = (sent == bad_beat) ? 2'b10 : 2'b00;
        bus.rlast  = (sent == 31) || (sent == early_last);
        pend = 1'b1;
        if (bus.rready === 1'b1) begin
          exp_d[sent] = bus.rdata;
          sent++;
          dv_due = 1'b1;
          pend = 1'b0;
          if (sent == 32) hs_last = cyc;
        end
      end else begin
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
      end
      if (last_seen >= 0 && cyc >= last_seen + 2) done = 1'b1;
      tick();
      cyc++;
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;

    chk({tag, ".no_timeout"}, 32'(done), 32'd1);
    chk({tag, ".beats"}, 32'(got), 32'd32);
    chk({tag, ".beat_content"}, 32'(bad_beat_cnt), 32'd0);
    chk({tag, ".beat_hold"}, 32'(bad_hold), 32'd0);
    chk({tag, ".consecutive_dv"}, 32'(consec), 32'd0);
    chk({tag, ".last_pulses"}, 32'(last_cnt), 32'd1);
    chk({tag, ".last_latency"}, 32'(last_seen - hs_last), 32'd2);
    chk({tag, ".fill_err"}, 32'(bus.fill_err), 32'(exp_err));

    bad_seq = 0;
    for (int d = 0; d < 3; d++) begin
      if (bus.arvalid !== 1'b0 || bus.busy !== 1'b1) bad_seq++;
      tick();
    end
    chk({tag, ".miss_level_hold"}, 32'(bad_seq), 32'd0);
    bus.miss = 1'b0;
    tick();
    chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".err_sticky"}, 32'(bus.fill_err), 32'(exp_err));
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    reset         = 1'b1;
    bus.miss      = 1'b0;
    bus.miss_addr = '0;
    bus.arready   = 1'b0;
    bus.rdata     = '0;
    bus.rresp     = 2'b00;
    bus.rlast     = 1'b0;
    bus.rvalid    = 1'b0;
    tick();
    tick();
    chk("reset.arvalid", 32'(bus.arvalid), 32'd0);
    chk("reset.rready", 32'(bus.rready), 32'd0);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.dv", 32'(bus.mem_data_valid), 32'd0);
    chk("reset.last", 32'(bus.mem_last), 32'd0);
    chk("reset.err", 32'(bus.fill_err), 32'd0);
    chk("reset.mem_addr", bus.mem_addr, 32'd0);
    chk("reset.wstb", 32'(bus.mem_wstb), 32'hF);
    chk("reset.arlen", 32'(bus.arlen), 32'd31);
    chk("reset.arsize", 32'(bus.arsize), 32'd2);
    chk("reset.arburst", 32'(bus.arburst), 32'd1);
    chk("reset.arid", 32'(bus.arid), 32'h3);
    reset = 1'b0;
    tick();

    do_fill("basic",   32'h0001_23C4, 0, 100, 1'b0, -1, -1, 0, 1'b0, 1'b0);
    do_fill("ar_bp",   32'h0000_1000, 5, 100, 1'b0, -1, -1, 0, 1'b0, 1'b0);
    do_fill("sparse",  32'h4000_0F7C, 1,  30, 1'b1, -1, -1, 0, 1'b0, 1'b0);
    do_fill("bad_resp",32'h0000_2010, 0, 100, 1'b0,  7, -1, 0, 1'b0, 1'b1);
    do_fill("rlast20", 32'h0000_3000, 0,  60, 1'b0, -1, 20, 0, 1'b1, 1'b1);
    do_fill("clean",   32'h0000_4004, 2, 100, 1'b0, -1, -1, 0, 1'b1, 1'b0);
    do_fill("abort",   32'h0000_5000, 0, 100, 1'b0,  3, -1, 10, 1'b0, 1'b1);
    tick();
    tick();
    reset = 1'b0;
    tick();
    do_fill("post_rst",32'h8000_0000, 0, 100, 1'b0, -1, -1, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
